recon_luma4x4: RTL and testbench
================================

// Module: recon_luma4x4
// PURPOSE
//  Decoder-side inverse of the luma 4x4 residual stage.
//  Reconstructs one 4x4 luma block as recon = clip255(pred + res), one row per cycle.
//  Sits after mode selection and inverse transform.
//  Feeds reconstructed pixels, plus bottom-row/right-column neighbours, back to the
//  intra predictors. Tracks block position (0..15) within the 16x16 macroblock.
// PARAMETERS
//  RES_W  9  width of signed residual samples (two's complement), range 8..16
// PORTS
//  clk         in   1          rising-edge clock
//  reset       in   1          synchronous, active-high reset
//  in_valid    in   1          pred/res block presented
//  in_ready    out  1          block can be accepted
//  pred        in   8 x16      unsigned prediction, raster order (idx = 4*row+col)
//  res         in   RES_W x16  signed residual, same order
//  out_valid   out  1          recon block valid
//  out_ready   in   1          consumer accepts recon block
//  recon       out  8 x16      reconstructed pixels, raster order
//  bottom_row  out  8 x4       recon[12..15], for the block below
//  right_col   out  8 x4       recon[3,7,11,15], for the block to the right
//  clip_any    out  1          at least one pixel of this block saturated
//  blk_idx     out  4          index of the block currently on recon (0..15)
//  mb_done     out  1          one-cycle pulse on the output handshake of blk_idx==15
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=1; out_valid=0; recon/bottom_row/right_col=0;
//   clip_any=0; blk_idx=0; mb_done=0.
//  Reset asserted in any state aborts the block in flight; nothing is output.
//  FSM states: IDLE, ROW, OUT.
//   IDLE: in_ready=1.
//    On in_valid&in_ready: register all pred/res, set row=0, clear clip accumulator,
//    go to ROW.
//   ROW: in_ready=0. Each cycle computes the 4 pixels of row `row` into recon regs.
//    clip flags are OR-ed into the accumulator; row increments.
//    On row==3: go to OUT; bottom_row, right_col and clip_any update on the same edge.
//   OUT: out_valid=1; recon, clip_any and blk_idx are stable until the handshake.
//    On out_valid&out_ready: go to IDLE; blk_idx wraps 15->0; mb_done=1 for that cycle only.
//  Latency: out_valid rises 4 cycles after the accept edge.
//   Minimum block period is 6 cycles (accept, 4 rows, output handshake).
//   in_ready is low in ROW and OUT; there is no input/output overlap.
//  Inputs are sampled only at the accept edge; later changes to pred/res are ignored.
//  Arithmetic per pixel:
//   s = {0,pred} + sign_ext(res), width RES_W+2.
//   s<0 -> 0; s>255 -> 255; otherwise s[7:0].
//   Any saturation sets the clip flag.
//  recon keeps its last value in IDLE and ROW (rows overwrite progressively).
//   Consumers sample recon only while out_valid=1.
//  in_valid while not ready: held by the producer (valid/ready rule); the block does
//   not register it.
//  out_ready held low: the block stays in OUT indefinitely with outputs frozen.
//  mb_done never asserts when reset and the handshake coincide; reset wins.
// TESTING
//  T1 pass-through: pred all 100, res all 0 -> recon all 100, clip_any=0,
//     out_valid rises exactly 4 cycles after the accept edge.
//  T2 saturation: pred=250, res=+20 -> 255; pred=5, res=-20 -> 0;
//     both in one block -> clip_any=1; res=+5 on 250 -> 255 with no clip.
//  T3 row mapping: pred[i]=i, res[i]=16*i -> recon[i]=17*i (i<=15),
//     bottom_row={204,221,238,255}, right_col={51,119,187,255}.
//  T4 backpressure: out_ready low 10 cycles -> recon/blk_idx stable,
//     in_ready=0, second block is not accepted until the handshake.
//  T5 macroblock wrap: 17 back-to-back blocks -> blk_idx 0..15 then 0;
//     mb_done pulses once, on the 16th output handshake only.
//  T6 mid-block reset: reset in ROW (row==2) -> next cycle in_ready=1, out_valid=0,
//     blk_idx=0; the next accepted block reconstructs correctly.

Source files
------------

// File: rtl/recon_luma4x4.sv
// Luma 4x4 reconstruction: recon = clip255(pred + res), one row per cycle,
// with neighbour edges for intra prediction and block position in the macroblock.
module recon_luma4x4 #(
  parameter int RES_W = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0][7:0]       pred,
  input  logic [15:0][RES_W-1:0] res,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0][7:0]       recon,
  output logic [3:0][7:0]        bottom_row,
  output logic [3:0][7:0]        right_col,
  output logic                   clip_any,
  output logic [3:0]             blk_idx,
  output logic                   mb_done,
  output logic [1:0]             fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds valid and data until then, and neither side
  // may make valid wait on ready.

  localparam int SW = RES_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   state;
  logic [1:0]               row;
  logic                     clip_acc;
  logic [15:0][7:0]         pred_q;
  logic [15:0][RES_W-1:0]   res_q;
  logic [3:0][7:0]          row_pix;
  logic [3:0]               row_clip;

  assign fsm_state = state;

  // Saturating add for the four pixels of the current row.
  always_comb begin
    row_pix  = '0;
    row_clip = '0;
    for (int c = 0; c < 4; c++) begin
      logic signed [SW-1:0] s;
      logic [RES_W-1:0]     r;
      logic [7:0]           p;
      p = pred_q[{row, 2'(c)}];
      r = res_q[{row, 2'(c)}];
      s = $signed({{(SW-8){1'b0}}, p}) + $signed({{2{r[RES_W-1]}}, r});
      if (s[SW-1]) begin
        row_pix[c]  = 8'd0;
        row_clip[c] = 1'b1;
      end else if (|s[SW-2:8]) begin
        row_pix[c]  = 8'd255;
        row_clip[c] = 1'b1;
      end else begin
        row_pix[c]  = s[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      row        <= 2'd0;
      clip_acc   <= 1'b0;
      pred_q     <= '0;
      res_q      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      recon      <= '0;
      bottom_row <= '0;
      right_col  <= '0;
      clip_any   <= 1'b0;
      blk_idx    <= 4'd0;
      mb_done    <= 1'b0;
    end else begin
      mb_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            pred_q   <= pred;
            res_q    <= res;
            row      <= 2'd0;
            clip_acc <= 1'b0;
            in_ready <= 1'b0;
            state    <= ROW;
          end
        end
        ROW: begin
          for (int c = 0; c < 4; c++) begin
            recon[{row, 2'(c)}] <= row_pix[c];
          end
          clip_acc <= clip_acc | (|row_clip);
          row      <= row + 2'd1;
          if (row == 2'd3) begin
            // Rows 0..2 are already in recon; the last column comes from this row.
            bottom_row <= row_pix;
            right_col  <= {row_pix[3], recon[11], recon[7], recon[3]};
            clip_any   <= clip_acc | (|row_clip);
            out_valid  <= 1'b1;
            state      <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            blk_idx   <= blk_idx + 4'd1;
            mb_done   <= (blk_idx == 4'd15);
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recon_luma4x4.sv
// Bench for recon_luma4x4: directed and random blocks checked against an
// integer reference model of clip255(pred + res).
module tb_recon_luma4x4;

  localparam int RES_W = 9;
  typedef logic [15:0][7:0] blk_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [15:0][7:0]       pred = '0;
  logic [15:0][RES_W-1:0] res = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [15:0][7:0]       recon;
  logic [3:0][7:0]        bottom_row;
  logic [3:0][7:0]        right_col;
  logic                   clip_any;
  logic [3:0]             blk_idx;
  logic                   mb_done;
  logic [1:0]             fsm_state;

  recon_luma4x4 #(.RES_W(RES_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pred(pred), .res(res), .out_valid(out_valid), .out_ready(out_ready),
    .recon(recon), .bottom_row(bottom_row), .right_col(right_col),
    .clip_any(clip_any), .blk_idx(blk_idx), .mb_done(mb_done),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_blk = 0;
  int cur_p[16];
  int cur_r[16];
  logic [127:0] exp_q[$];

  // Reference model: per-pixel integer sum, clamped to 0..255.
  function automatic blk_t ref_recon();
    blk_t b;
    for (int i = 0; i < 16; i++) begin
      int s;
      s = cur_p[i] + cur_r[i];
      if (s < 0) s = 0;
      if (s > 255) s = 255;
      b[i] = 8'(s);
    end
    return b;
  endfunction

  function automatic logic ref_clip();
    logic c;
    c = 1'b0;
    for (int i = 0; i < 16; i++)
      if (cur_p[i] + cur_r[i] < 0 || cur_p[i] + cur_r[i] > 255) c = 1'b1;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_blk = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 16; i++) begin
      pred[i] = 8'(cur_p[i]);
      res[i]  = RES_W'(cur_r[i]);
    end
  endtask

  task automatic accept_block(output int ok);
    int n;
    drive_inputs();
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      ok = 0;
      in_valid = 1'b0;
    end else begin
      tick();
      ok = 1;
      in_valid = 1'b0;
      // Scramble inputs after the accept edge; the block must ignore them.
      for (int i = 0; i < 16; i++) begin
        pred[i] = 8'($urandom);
        res[i]  = RES_W'($urandom);
      end
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic handshake(output logic mb);
    out_ready = 1'b1;
    tick();
    mb = mb_done;
    out_ready = 1'b0;
    exp_blk = (exp_blk + 1) % 16;
  endtask

  task automatic run_block(output int lat, output blk_t rc, output logic cl,
                           output logic [3:0] bi, output logic mb);
    int ok;
    accept_block(ok);
    if (ok == 0) begin
      lat = -1;
      rc = '0; cl = 1'b0; bi = '0; mb = 1'b0;
    end else begin
      wait_out(lat);
      rc = recon;
      cl = clip_any;
      bi = blk_idx;
      if (lat >= 0) handshake(mb);
      else mb = 1'b0;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || recon !== '0 || bottom_row !== '0 ||
        right_col !== '0 || clip_any !== 1'b0 || blk_idx !== 4'd0 || mb_done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b recon=%h bottom=%h right=%h clip=%b blk=%0d mb=%b, required 1 0 0 0 0 0 0 0",
               in_ready, out_valid, recon, bottom_row, right_col, clip_any, blk_idx, mb_done);
    end
  endtask

  task automatic test_passthrough();
    int lat; blk_t rc; logic cl; logic [3:0] bi; logic mb;
    for (int i = 0; i < 16; i++) begin cur_p[i] = 100; cur_r[i] = 0; end
    run_block(lat, rc, cl, bi, mb);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL pass_latency: got %0d required 4", lat); end
    tests++;
    if (rc !== {16{8'd100}}) begin fails++; $display("FAIL pass_recon: got %h required all 0x64", rc); end
    tests++;
    if (cl !== 1'b0) begin fails++; $display("FAIL pass_clip: got %b required 0", cl); end
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL pass_after_hs: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_saturation();
    int lat; blk_t rc; logic cl; logic [3:0] bi; logic mb;
    for (int i = 0; i < 16; i++) begin cur_p[i] = 128; cur_r[i] = 7; end
    cur_p[0] = 250; cur_r[0] = 20;
    cur_p[1] = 5;   cur_r[1] = -20;
    cur_p[2] = 250; cur_r[2] = 5;
    cur_p[3] = 255; cur_r[3] = 0;
    cur_p[4] = 0;   cur_r[4] = -1;
    run_block(lat, rc, cl, bi, mb);
    tests++;
    if (rc[0] !== 8'd255 || rc[1] !== 8'd0 || rc[2] !== 8'd255 || rc[3] !== 8'd255 ||
        rc[4] !== 8'd0 || rc[5] !== 8'd135) begin
      fails++; $display("FAIL sat_pixels: got %h required 255,0,255,255,0,135 in pixels 0..5", rc);
    end
    tests++;
    if (cl !== 1'b1) begin fails++; $display("FAIL sat_clip: got %b required 1", cl); end
    for (int i = 0; i < 16; i++) begin cur_p[i] = (i == 3) ? 255 : 250; cur_r[i] = (i == 3) ? 0 : 5; end
    cur_p[7] = 0; cur_r[7] = 0;
    run_block(lat, rc, cl, bi, mb);
    tests++;
    if (rc !== ref_recon() || cl !== 1'b0) begin
      fails++; $display("FAIL sat_edge_noclip: got %h clip=%b required %h clip=0", rc, cl, ref_recon());
    end
  endtask

  task automatic test_row_mapping();
    int lat; blk_t rc; logic cl; logic [3:0] bi; logic mb;
    for (int i = 0; i < 16; i++) begin cur_p[i] = i; cur_r[i] = 16 * i; end
    run_block(lat, rc, cl, bi, mb);
    tests++;
    if (rc !== ref_recon()) begin fails++; $display("FAIL row_recon: got %h required %h", rc, ref_recon()); end
    tests++;
    if (bottom_row !== {8'd255, 8'd238, 8'd221, 8'd204}) begin
      fails++; $display("FAIL row_bottom: got %h required ffeeddcc", bottom_row);
    end
    tests++;
    if (right_col !== {8'd255, 8'd187, 8'd119, 8'd51}) begin
      fails++; $display("FAIL row_right: got %h required ffbb7733", right_col);
    end
  endtask

  task automatic test_backpressure();
    int ok, lat; blk_t e1; logic [3:0] bi; logic mb; int bad;
    for (int i = 0; i < 16; i++) begin cur_p[i] = $urandom_range(0, 255); cur_r[i] = $urandom_range(0, 511) - 256; end
    e1 = ref_recon();
    accept_block(ok);
    wait_out(lat);
    tests++;
    if (ok == 0 || lat !== 4) begin fails++; $display("FAIL bp_first_out: ok=%0d latency=%0d required 1 4", ok, lat); end
    bi = blk_idx;
    // Offer a second block while the first is held on the output.
    for (int i = 0; i < 16; i++) begin cur_p[i] = $urandom_range(0, 255); cur_r[i] = $urandom_range(0, 511) - 256; end
    exp_q.push_back(ref_recon());
    drive_inputs();
    in_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (recon !== e1 || blk_idx !== bi || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL bp_hold: %0d of 10 cycles unstable, recon=%h required %h in_ready=%b required 0", bad, recon, e1, in_ready);
    end
    tests++;
    if (bi !== 4'(exp_blk)) begin fails++; $display("FAIL bp_blk_idx: got %0d required %0d", bi, exp_blk); end
    handshake(mb);
    accept_block(ok);
    wait_out(lat);
    tests++;
    if (ok == 0 || lat !== 4 || recon !== exp_q[0]) begin
      fails++; $display("FAIL bp_second: ok=%0d lat=%0d recon=%h required %h", ok, lat, recon, exp_q[0]);
    end
    void'(exp_q.pop_front());
    handshake(mb);
  endtask

  task automatic test_random();
    int lat; blk_t rc; logic cl; logic [3:0] bi; logic mb; logic exp_c;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 16; i++) begin
        cur_p[i] = $urandom_range(0, 255);
        cur_r[i] = (n % 2 == 0) ? $urandom_range(0, 511) - 256 : $urandom_range(0, 40) - 20;
      end
      exp_q.push_back(ref_recon());
      exp_c = ref_clip();
      run_block(lat, rc, cl, bi, mb);
      tests++;
      if (rc !== exp_q[0] || cl !== exp_c || lat !== 4 || bi !== 4'(exp_blk == 0 ? 15 : exp_blk - 1)) begin
        fails++;
        $display("FAIL random_%0d: recon=%h clip=%b lat=%0d blk=%0d required %h %b 4 %0d",
                 n, rc, cl, lat, bi, exp_q[0], exp_c, exp_blk == 0 ? 15 : exp_blk - 1);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    int lat; blk_t rc; logic cl; logic [3:0] bi; logic mb; int pulses; int bad_idx; int pulse_at;
    apply_reset();
    pulses = 0; bad_idx = 0; pulse_at = -1;
    for (int n = 0; n < 17; n++) begin
      for (int i = 0; i < 16; i++) begin cur_p[i] = $urandom_range(0, 255); cur_r[i] = $urandom_range(0, 100) - 50; end
      run_block(lat, rc, cl, bi, mb);
      if (bi !== 4'(n % 16) || rc !== ref_recon()) bad_idx++;
      if (mb === 1'b1) begin pulses++; pulse_at = n; end
      tick();
      if (mb_done !== 1'b0) pulses += 100;
    end
    tests++;
    if (bad_idx != 0) begin fails++; $display("FAIL wrap_blk_idx: %0d blocks with wrong index or pixels, required 0", bad_idx); end
    tests++;
    if (pulses != 1 || pulse_at != 15) begin
      fails++; $display("FAIL wrap_mb_done: pulses=%0d at block %0d required 1 at block 15", pulses, pulse_at);
    end
  endtask

  task automatic test_reset_wins();
    int ok, lat; blk_t rc; logic cl; logic [3:0] bi; logic mb;
    apply_reset();
    for (int n = 0; n < 15; n++) begin
      for (int i = 0; i < 16; i++) begin cur_p[i] = n; cur_r[i] = i; end
      run_block(lat, rc, cl, bi, mb);
    end
    accept_block(ok);
    wait_out(lat);
    tests++;
    if (blk_idx !== 4'd15 || out_valid !== 1'b1) begin
      fails++; $display("FAIL rw_setup: blk=%0d out_valid=%b required 15 1", blk_idx, out_valid);
    end
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    exp_blk = 0;
    tests++;
    if (mb_done !== 1'b0 || blk_idx !== 4'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL rw_mb_done: mb=%b blk=%0d out_valid=%b required 0 0 0", mb_done, blk_idx, out_valid);
    end
  endtask

  task automatic test_mid_reset();
    int ok, lat; blk_t rc; logic cl; logic [3:0] bi; logic mb;
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 16; i++) begin cur_p[i] = 50; cur_r[i] = n; end
      run_block(lat, rc, cl, bi, mb);
    end
    for (int i = 0; i < 16; i++) begin cur_p[i] = 200; cur_r[i] = 100; end
    accept_block(ok);
    tick();
    tick();
    tests++;
    if (fsm_state !== 2'd1 || blk_idx === 4'd0) begin
      fails++; $display("FAIL mid_setup: state=%0d blk=%0d required ROW(1) nonzero", fsm_state, blk_idx);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_blk = 0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || blk_idx !== 4'd0 || mb_done !== 1'b0) begin
      fails++; $display("FAIL mid_reset: in_ready=%b out_valid=%b blk=%0d mb=%b required 1 0 0 0",
                        in_ready, out_valid, blk_idx, mb_done);
    end
    for (int i = 0; i < 16; i++) begin cur_p[i] = $urandom_range(0, 255); cur_r[i] = $urandom_range(0, 511) - 256; end
    run_block(lat, rc, cl, bi, mb);
    tests++;
    if (rc !== ref_recon() || cl !== ref_clip() || lat !== 4 || bi !== 4'd0) begin
      fails++; $display("FAIL mid_next_block: recon=%h clip=%b lat=%0d blk=%0d required %h %b 4 0",
                        rc, cl, lat, bi, ref_recon(), ref_clip());
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_saturation();
    test_row_mapping();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_back_to_back();
    test_reset_wins();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
